uart_tx_serializer: RTL and testbench
=====================================

// Module: uart_tx_serializer
// PURPOSE
//  Transmit serializer directly downstream of the baud generator. Accepts parallel bytes
//  over a valid/ready handshake and shifts them out LSB-first as 8N1-style UART frames
//  (start, data, optional parity, stop). Bit boundaries are set by the single-cycle
//  baud_clk strobe. A one-entry holding register lets frames run back-to-back with no gap.
// PARAMETERS
//  DATA_BITS   8  data bits per frame (5..8)
//  STOP_BITS   1  stop bits per frame (1 or 2)
//  PARITY_EN   0  1 = insert parity bit after data
//  PARITY_ODD  0  0 = even parity, 1 = odd parity (used only when PARITY_EN=1)
// PORTS
//  clk         in   1          system clock (48 MHz)
//  reset       in   1          synchronous, active-high reset
//  baud_clk    in   1          one-clk-wide bit-period strobe from baud generator
//  tx_data     in   DATA_BITS  byte to send, sampled when tx_valid && tx_ready
//  tx_valid    in   1          tx_data is valid
//  tx_ready    out  1          holding register empty; = !hold_full
//  serial_out  out  1          UART line, idle high, registered
//  tx_busy     out  1          1 whenever state != IDLE
// BEHAVIOUR
//  - One clock domain (clk); reset is synchronous and active-high. All outputs are registered.
//  - Reset: serial_out=1, tx_ready=1, tx_busy=0, hold_full=0, state=IDLE, counters=0.
//    Reset mid-frame aborts it: line high on the next edge. No partial bits are resumed.
//  - Accept: on an edge with tx_valid && tx_ready, latch tx_data into hold and set hold_full.
//    tx_ready falls on the following cycle. While tx_ready=0, tx_valid is ignored.
//  - States: IDLE, START, DATA, PARITY, STOP. All transitions occur only on edges with baud_clk=1.
//    * IDLE & hold_full & baud_clk -> START: serial_out<=0, shift<=hold, hold_full<=0, bit_cnt<=0.
//    * START & baud_clk -> DATA: serial_out<=shift[0].
//    * DATA & baud_clk: if bit_cnt<DATA_BITS-1, shift right, serial_out<=next bit, bit_cnt++.
//      Otherwise go to PARITY if PARITY_EN, else STOP.
//    * PARITY: serial_out = ^data (even) or ~^data (odd). Parity is computed from the byte at load.
//    * STOP: serial_out<=1 for STOP_BITS strobe periods.
//      At the strobe ending the last stop period: if hold_full -> START (start bit, no idle gap).
//      Otherwise -> IDLE.
//  - Each bit is held exactly one strobe interval.
//    Frame = 1+DATA_BITS+PARITY_EN+STOP_BITS strobe intervals.
//  - Accept in the same cycle as a baud_clk in IDLE: the byte is loaded, but the start bit
//    waits for the next strobe. That strobe is not consumed.
//  - Hold drain and new accept never occur in the same cycle (tx_ready derives from registered hold_full).
//  - baud_clk asserted on consecutive cycles is illegal input. Each asserted cycle still counts as one bit.
// TESTING (bench drives baud_clk once every 8 clk)
//  1 Reset: assert reset 3 clk -> serial_out=1, tx_ready=1, tx_busy=0. Line stays high with no tx_valid.
//  2 Send 0xA5, no parity: line = 0,1,0,1,0,0,1,0,1,1, each level for 8 clk.
//    tx_busy=1 from start bit to end of stop bit.
//  3 PARITY_EN=1: even with 0x07 -> parity bit 1; odd with 0x07 -> 0; even with 0x00 -> 0.
//  4 Back-to-back: hold tx_valid with 0x55 then 0xFF. The second start bit follows the first
//    stop bit with zero idle clocks. tx_ready re-rises one clk after each hold drain.
//  5 Reset asserted during data bit 3 -> serial_out=1 next clk, tx_ready=1, tx_busy=0.
//    A new 0x3C frame then transmits cleanly.
//  6 STOP_BITS=2: line high 16 clk after data. An accept coincident with a strobe starts
//    the frame one strobe later.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer
// UART transmit serializer fed by a baud-rate strobe. Bytes arrive over a
// valid/ready handshake into a one-entry holding register and are shifted out
// LSB-first as start / data / optional parity / stop frames. The holding
// register lets the next frame start directly after the last stop bit.
module uart_tx_serializer #(
   parameter int DATA_BITS  = 8,
   parameter int STOP_BITS  = 1,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 baud_clk,
   input  logic [DATA_BITS-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 tx_ready,
   output logic                 serial_out,
   output logic                 tx_busy
);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } txState_t;

   localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
   localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

   txState_t             state_q;
   logic [DATA_BITS-1:0] hold_q;
   logic                 holdFull_q;
   logic [DATA_BITS-1:0] shift_q;
   logic [2:0]           bitCnt_q;
   logic                 stopCnt_q;
   logic                 parity_q;
   logic                 serialOut_q;
   logic                 busy_q;

   logic                 accept_d;
   logic                 startFrame_d;
   logic                 loadParity_d;

   // Handshake, frame-start decision and the parity of the byte about to be
   // loaded. A frame starts either from IDLE or straight out of the final
   // stop period, so back-to-back frames need no idle gap.
   always_comb begin
      accept_d     = tx_valid && !holdFull_q;
      startFrame_d = baud_clk && holdFull_q &&
                     ((state_q == IDLE) ||
                      ((state_q == STOP) && (stopCnt_q == LAST_STOP)));
      loadParity_d = (PARITY_ODD != 0) ? ~^hold_q : ^hold_q;
   end

   // Transmit FSM with the holding register; every line change is registered
   // and only happens on a baud strobe. Accept and drain never collide
   // because accept needs an empty hold and drain needs a full one.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= IDLE;
         hold_q      <= '0;
         holdFull_q  <= 1'b0;
         shift_q     <= '0;
         bitCnt_q    <= 3'd0;
         stopCnt_q   <= 1'b0;
         parity_q    <= 1'b0;
         serialOut_q <= 1'b1;
         busy_q      <= 1'b0;
      end else begin
         if (accept_d) begin
            hold_q     <= tx_data;
            holdFull_q <= 1'b1;
         end
         if (startFrame_d) begin
            state_q     <= START;
            serialOut_q <= 1'b0;
            shift_q     <= hold_q;
            parity_q    <= loadParity_d;
            holdFull_q  <= 1'b0;
            bitCnt_q    <= 3'd0;
            stopCnt_q   <= 1'b0;
            busy_q      <= 1'b1;
         end else if (baud_clk) begin
            case (state_q)
               START: begin
                  state_q     <= DATA;
                  serialOut_q <= shift_q[0];
               end
               DATA: begin
                  if (bitCnt_q != LAST_BIT) begin
                     shift_q     <= shift_q >> 1;
                     serialOut_q <= shift_q[1];
                     bitCnt_q    <= bitCnt_q + 3'd1;
                  end else if (PARITY_EN != 0) begin
                     state_q     <= PARITY;
                     serialOut_q <= parity_q;
                  end else begin
                     state_q     <= STOP;
                     serialOut_q <= 1'b1;
                     stopCnt_q   <= 1'b0;
                  end
               end
               PARITY: begin
                  state_q     <= STOP;
                  serialOut_q <= 1'b1;
                  stopCnt_q   <= 1'b0;
               end
               STOP: begin
                  serialOut_q <= 1'b1;
                  if (stopCnt_q == LAST_STOP) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     stopCnt_q <= stopCnt_q + 1'b1;
                  end
               end
               default: begin
                  state_q     <= IDLE;
                  serialOut_q <= 1'b1;
                  busy_q      <= 1'b0;
               end
            endcase
         end
      end
   end

   assign tx_ready   = ~holdFull_q;
   assign serial_out = serialOut_q;
   assign tx_busy    = busy_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// tb_uart_tx_serializer
// Directed bench for uart_tx_serializer. Four instances cover the default
// 8N1 frame, even parity, odd parity and two stop bits. baud_clk pulses once
// every 8 clk; line levels are sampled mid-bit on falling clock edges.
module tb_uart_tx_serializer;

   typedef struct {
      string      name;
      int         inst;
      logic [7:0] data;
      string      expBits;
   } FrameVec;

   logic       clk;
   logic       reset;
   logic       baudClk;
   logic [7:0] txData    [4];
   logic       txValid   [4];
   logic       txReady   [4];
   logic       serialOut [4];
   logic       txBusy    [4];

   int checks = 0;
   int errors = 0;

   FrameVec vecs [9];

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(0), .PARITY_ODD(0)) dutDefault (
      .clk(clk), .reset(reset), .baud_clk(baudClk), .tx_data(txData[0]), .tx_valid(txValid[0]),
      .tx_ready(txReady[0]), .serial_out(serialOut[0]), .tx_busy(txBusy[0]));

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(0)) dutEven (
      .clk(clk), .reset(reset), .baud_clk(baudClk), .tx_data(txData[1]), .tx_valid(txValid[1]),
      .tx_ready(txReady[1]), .serial_out(serialOut[1]), .tx_busy(txBusy[1]));

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) dutOdd (
      .clk(clk), .reset(reset), .baud_clk(baudClk), .tx_data(txData[2]), .tx_valid(txValid[2]),
      .tx_ready(txReady[2]), .serial_out(serialOut[2]), .tx_busy(txBusy[2]));

   uart_tx_serializer #(.DATA_BITS(8), .STOP_BITS(2), .PARITY_EN(0), .PARITY_ODD(0)) dutStop2 (
      .clk(clk), .reset(reset), .baud_clk(baudClk), .tx_data(txData[3]), .tx_valid(txValid[3]),
      .tx_ready(txReady[3]), .serial_out(serialOut[3]), .tx_busy(txBusy[3]));

   // Free-running system clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Baud strobe: one clk wide, once every 8 clk, changed on falling edges.
   initial begin
      baudClk = 1'b0;
      forever begin
         repeat (7) @(negedge clk);
         baudClk = 1'b1;
         @(negedge clk);
         baudClk = 1'b0;
      end
   end

   // Compare one value and report a failure.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   // Compare a captured bit string against the expected one.
   task automatic checkString(input string name, input string actual, input string expected);
      checks++;
      if (actual != expected) begin
         errors++;
         $display("[TB] FAIL %s: got %s, expected %s", name, actual, expected);
      end
   endtask

   // Wait (bounded) on a falling edge for tx_ready of one instance.
   task automatic waitReady(input int inst);
      int n;
      n = 0;
      @(negedge clk);
      while (txReady[inst] !== 1'b1 && n < 200) begin
         @(negedge clk);
         n++;
      end
      checkOutput("readyWait", 32'(txReady[inst]), 32'd1);
   endtask

   // Wait (bounded) for the start bit; reports how many falling edges it took.
   task automatic waitStart(input int inst, output int cycles);
      cycles = 0;
      while (serialOut[inst] !== 1'b0 && cycles < 200) begin
         @(negedge clk);
         cycles++;
      end
      checkOutput("startWait", 32'(serialOut[inst]), 32'd0);
   endtask

   // Sample line, busy and ready once per bit, 8 clk apart.
   task automatic captureBits(input int inst, input int n, output string bits,
                              output string ready, output logic busyOk);
      bits   = "";
      ready  = "";
      busyOk = 1'b1;
      for (int i = 0; i < n; i++) begin
         if (serialOut[inst] === 1'b1) bits = {bits, "1"};
         else                          bits = {bits, "0"};
         if (txReady[inst] === 1'b1)   ready = {ready, "1"};
         else                          ready = {ready, "0"};
         if (txBusy[inst] !== 1'b1) busyOk = 1'b0;
         repeat (8) @(negedge clk);
      end
   endtask

   // Hand one byte to an instance over the valid/ready handshake.
   task automatic applyStimulus(input int inst, input logic [7:0] data);
      waitReady(inst);
      txData[inst]  = data;
      txValid[inst] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      txValid[inst] = 1'b0;
   endtask

   // Send one byte and compare its whole frame plus the idle line afterwards.
   task automatic sendFrame(input FrameVec v);
      int    n;
      string bits;
      string ready;
      string expReady;
      logic  busyOk;
      applyStimulus(v.inst, v.data);
      waitStart(v.inst, n);
      repeat (3) @(negedge clk);
      captureBits(v.inst, v.expBits.len(), bits, ready, busyOk);
      expReady = "";
      for (int i = 0; i < v.expBits.len(); i++) expReady = {expReady, "1"};
      checkString({v.name, "_bits"}, bits, v.expBits);
      checkString({v.name, "_ready"}, ready, expReady);
      checkOutput({v.name, "_busy"}, 32'(busyOk), 32'd1);
      checkOutput({v.name, "_idleLine"}, 32'(serialOut[v.inst]), 32'd1);
      checkOutput({v.name, "_idleBusy"}, 32'(txBusy[v.inst]), 32'd0);
   endtask

   initial begin
      int    n;
      string bits;
      string ready;
      logic  busyOk;
      logic  stayedHigh;
      FrameVec v;

      vecs[0] = '{"defaultA5",    0, 8'hA5, "0101001011"};
      vecs[1] = '{"evenParity07", 1, 8'h07, "01110000011"};
      vecs[2] = '{"oddParity07",  2, 8'h07, "01110000001"};
      vecs[3] = '{"evenParity00", 1, 8'h00, "00000000001"};
      vecs[4] = '{"oddParity00",  2, 8'h00, "00000000011"};
      vecs[5] = '{"evenParityFF", 1, 8'hFF, "01111111101"};
      vecs[6] = '{"evenParity81", 1, 8'h81, "01000000101"};
      vecs[7] = '{"stop2A5",      3, 8'hA5, "01010010111"};
      vecs[8] = '{"default3C",    0, 8'h3C, "0001111001"};

      for (int i = 0; i < 4; i++) begin
         txData[i]  = 8'h00;
         txValid[i] = 1'b0;
      end

      // Reset for 3 clk, then the line must idle high with nothing offered.
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("resetLine%0d", i),  32'(serialOut[i]), 32'd1);
         checkOutput($sformatf("resetReady%0d", i), 32'(txReady[i]),   32'd1);
         checkOutput($sformatf("resetBusy%0d", i),  32'(txBusy[i]),    32'd0);
      end
      stayedHigh = 1'b1;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (serialOut[0] !== 1'b1 || txBusy[0] !== 1'b0) stayedHigh = 1'b0;
      end
      checkOutput("idleNoValid", 32'(stayedHigh), 32'd1);

      // Table-driven single frames.
      for (int i = 0; i < 9; i++) sendFrame(vecs[i]);

      // Back-to-back: 0x55 then 0xFF with tx_valid held, no idle gap.
      waitReady(0);
      txData[0]  = 8'h55;
      txValid[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("b2bAccept1", 32'(txReady[0]), 32'd0);
      txData[0] = 8'hFF;
      waitStart(0, n);
      checkOutput("b2bReadyAfterDrain1", 32'(txReady[0]), 32'd1);
      @(negedge clk);
      checkOutput("b2bAccept2", 32'(txReady[0]), 32'd0);
      txValid[0] = 1'b0;
      repeat (2) @(negedge clk);
      captureBits(0, 20, bits, ready, busyOk);
      checkString("b2bBits", bits, "01010101010111111111");
      checkString("b2bReady", ready, "00000000001111111111");
      checkOutput("b2bBusy", 32'(busyOk), 32'd1);
      checkOutput("b2bIdleLine", 32'(serialOut[0]), 32'd1);

      // Reset during data bit 3 of 0xA5 (a 0 bit), then a clean 0x3C frame.
      applyStimulus(0, 8'hA5);
      waitStart(0, n);
      repeat (36) @(negedge clk);
      checkOutput("midBit3Low", 32'(serialOut[0]), 32'd0);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checkOutput("midResetLine",  32'(serialOut[0]), 32'd1);
      checkOutput("midResetReady", 32'(txReady[0]),   32'd1);
      checkOutput("midResetBusy",  32'(txBusy[0]),    32'd0);
      reset = 1'b0;
      v = '{"afterReset3C", 0, 8'h3C, "0001111001"};
      sendFrame(v);

      // Two stop bits: accept on a strobe edge, start bit one strobe later.
      waitReady(3);
      @(posedge baudClk);
      txData[3]  = 8'h3C;
      txValid[3] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      txValid[3] = 1'b0;
      checkOutput("coinReady", 32'(txReady[3]),   32'd0);
      checkOutput("coinLine",  32'(serialOut[3]), 32'd1);
      waitStart(3, n);
      checkOutput("coinStartDelay", 32'(n), 32'd8);
      repeat (3) @(negedge clk);
      captureBits(3, 11, bits, ready, busyOk);
      checkString("coinBits", bits, "00011110011");
      checkOutput("coinBusy", 32'(busyOk), 32'd1);
      checkOutput("coinIdleLine", 32'(serialOut[3]), 32'd1);
      checkOutput("coinIdleBusy", 32'(txBusy[3]),    32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
